// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronise / glitch-filter / edge-detect block.
// Holds the default parameter values and the filter counter width function.
package sync_pkg;

    localparam int DEF_CHANNELS      = 32'd4;
    localparam int DEF_SYNC_DELAY_CC = 32'd2;
    localparam int DEF_FILTER_CC     = 32'd4;
    localparam int DEF_INIT_LEVEL    = 32'd0;

    // Classification of what the filter decides on a given edge.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Counter must hold 0..filter_cc-1; sized with one spare code so filter_cc=1 still gets a bit.
    function automatic int cnt_width(input int filter_cc);
        return $clog2(filter_cc + 32'd1);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: capture flop plus synchroniser chain, persistence filter on the
// synchronised value, and registered one-cycle rise/fall pulses.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int SYNC_DELAY_CC = DEF_SYNC_DELAY_CC,
    parameter int FILTER_CC     = DEF_FILTER_CC,
    parameter int INIT_LEVEL    = DEF_INIT_LEVEL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(FILTER_CC);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(FILTER_CC - 32'd1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);
    localparam logic           INIT_BIT = (INIT_LEVEL != 32'd0);

    logic [SYNC_DELAY_CC:0] stage_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sync_s;
    edge_e                  edge_nxt_s;

    assign sync_s = stage_r[SYNC_DELAY_CC];

    // Capture flop (stage 0) followed by SYNC_DELAY_CC metastability stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_r <= {(SYNC_DELAY_CC + 1){INIT_BIT}};
        end else begin
            stage_r <= {stage_r[SYNC_DELAY_CC-1:0], sig_in};
        end
    end

    // Persistence filter: a differing level is accepted only once the counter has seen it FILTER_CC times.
    always_comb begin
        cnt_nxt_s   = CNT_ZERO;
        level_nxt_s = level_r;
        edge_nxt_s  = EDGE_NONE;
        if (sync_s == level_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s   = CNT_ZERO;
            level_nxt_s = sync_s;
            edge_nxt_s  = sync_s ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Filter state and edge pulses; pulses are registered so they coincide with the level change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            level_r <= INIT_BIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            case (edge_nxt_s)
                EDGE_RISE: begin
                    rise_r <= 1'b1;
                    fall_r <= 1'b0;
                end
                EDGE_FALL: begin
                    rise_r <= 1'b0;
                    fall_r <= 1'b1;
                end
                default: begin
                    rise_r <= 1'b0;
                    fall_r <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel asynchronous input conditioner: every bit gets its own
// synchroniser, glitch filter and edge detector; channels never interact.
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_DELAY_CC = DEF_SYNC_DELAY_CC,
    parameter int FILTER_CC     = DEF_FILTER_CC,
    parameter int INIT_LEVEL    = DEF_INIT_LEVEL
) (
    input  logic                piul1SyncClock,
    input  logic                piul1SyncResetN,
    input  logic [CHANNELS-1:0] piulvSigIn,
    output logic [CHANNELS-1:0] poulvSigOut,
    output logic [CHANNELS-1:0] poulvRise,
    output logic [CHANNELS-1:0] poulvFall
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        sync_filter_chan #(
            .SYNC_DELAY_CC (SYNC_DELAY_CC),
            .FILTER_CC     (FILTER_CC),
            .INIT_LEVEL    (INIT_LEVEL)
        ) u_chan (
            .clk    (piul1SyncClock),
            .rst_n  (piul1SyncResetN),
            .sig_in (piulvSigIn[ch]),
            .level  (poulvSigOut[ch]),
            .rise   (poulvRise[ch]),
            .fall   (poulvFall[ch])
        );
    end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Scoreboard bench: stimulus pushes hand-computed pulse events, monitors pop
// and compare whenever a pulse appears and track the expected filtered level.
module tb_sync_filter_edge;

    typedef struct {
        int cyc;
        int ch;
        bit rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_q = 1'b0;
    logic [3:0] in_a = 4'b0000;
    logic [3:0] out_a, rise_a, fall_a;
    logic [1:0] in_b = 2'b00;
    logic [1:0] out_b, rise_b, fall_b;
    logic [3:0] lvl_a = 4'b0000;
    logic [1:0] lvl_b = 2'b11;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q_a[$];
    exp_t       q_b[$];
    exp_t       e_a, e_b;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    sync_filter_edge dut_a (
        .piul1SyncClock  (clk),
        .piul1SyncResetN (rst_n),
        .piulvSigIn      (in_a),
        .poulvSigOut     (out_a),
        .poulvRise       (rise_a),
        .poulvFall       (fall_a)
    );

    sync_filter_edge #(
        .CHANNELS      (2),
        .SYNC_DELAY_CC (3),
        .FILTER_CC     (1),
        .INIT_LEVEL    (1)
    ) dut_b (
        .piul1SyncClock  (clk),
        .piul1SyncResetN (rst_n),
        .piulvSigIn      (in_b),
        .poulvSigOut     (out_b),
        .poulvRise       (rise_b),
        .poulvFall       (fall_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint ev_code(input int c, input int ch, input bit r);
        return longint'(c) * 256 + longint'(ch) * 2 + longint'(r);
    endfunction

    task automatic push_a(input int c, input int ch, input bit r);
        exp_t e;
        e.cyc = c; e.ch = ch; e.rise = r;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input int ch, input bit r);
        exp_t e;
        e.cyc = c; e.ch = ch; e.rise = r;
        q_b.push_back(e);
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the default-parameter instance.
    always @(negedge clk) begin
        if (!rst_q) lvl_a = 4'b0000;
        for (int ch = 0; ch < 4; ch++) begin
            if (rise_a[ch] || fall_a[ch]) begin
                chk("a_rise_and_fall", longint'(rise_a[ch] & fall_a[ch]), 0);
                if (q_a.size() == 0) begin
                    chk("a_unexpected_pulse", ev_code(cyc, ch, rise_a[ch]), 0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_pulse_event", ev_code(cyc, ch, rise_a[ch]), ev_code(e_a.cyc, e_a.ch, e_a.rise));
                    lvl_a[e_a.ch] = e_a.rise;
                end
            end
        end
        while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            e_a = q_a.pop_front();
            chk("a_missed_pulse", 0, ev_code(e_a.cyc, e_a.ch, e_a.rise));
            lvl_a[e_a.ch] = e_a.rise;
        end
        chk("a_sigout", longint'(out_a), longint'(lvl_a));
    end

    // Monitor for the unfiltered, inverted-reset instance.
    always @(negedge clk) begin
        if (!rst_q) lvl_b = 2'b11;
        for (int ch = 0; ch < 2; ch++) begin
            if (rise_b[ch] || fall_b[ch]) begin
                chk("b_rise_and_fall", longint'(rise_b[ch] & fall_b[ch]), 0);
                if (q_b.size() == 0) begin
                    chk("b_unexpected_pulse", ev_code(cyc, ch, rise_b[ch]), 0);
                end else begin
                    e_b = q_b.pop_front();
                    chk("b_pulse_event", ev_code(cyc, ch, rise_b[ch]), ev_code(e_b.cyc, e_b.ch, e_b.rise));
                    lvl_b[e_b.ch] = e_b.rise;
                end
            end
        end
        while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            e_b = q_b.pop_front();
            chk("b_missed_pulse", 0, ev_code(e_b.cyc, e_b.ch, e_b.rise));
            lvl_b[e_b.ch] = e_b.rise;
        end
        chk("b_sigout", longint'(out_b), longint'(lvl_b));
    end

    initial begin
        // B sees 0 against INIT_LEVEL=1 from the first sampled edge (5): fall at 5+3+1.
        push_b(9, 0, 1'b0);
        push_b(9, 1, 1'b0);

        wait_edge(1);
        chk("a_reset_sigout", longint'(out_a), 0);
        chk("a_reset_pulses", longint'({rise_a, fall_a}), 0);
        chk("b_reset_sigout", longint'(out_b), 3);
        chk("b_reset_pulses", longint'({rise_b, fall_b}), 0);

        wait_edge(4);
        rst_n = 1'b1;

        wait_edge(9);
        in_a[0] = 1'b1; push_a(16, 0, 1'b1);

        wait_edge(19);
        in_a[2] = 1'b1; push_a(26, 2, 1'b1);
        in_b[0] = 1'b1; push_b(24, 0, 1'b1);

        wait_edge(20);
        in_b[0] = 1'b0; push_b(25, 0, 1'b0);

        wait_edge(23);
        in_a[2] = 1'b0; push_a(30, 2, 1'b0);

        // three-cycle glitch on ch1 must be swallowed
        wait_edge(30);
        in_a[1] = 1'b1;
        wait_edge(33);
        in_a[1] = 1'b0;

        wait_edge(40);
        in_a[3] = 1'b1;
        in_b[1] = 1'b1; push_b(45, 1, 1'b1);
        wait_edge(42);
        in_a[3] = 1'b0;
        in_b[1] = 1'b0; push_b(47, 1, 1'b0);
        wait_edge(43);
        in_a[3] = 1'b1; push_a(50, 3, 1'b1);

        wait_edge(55);
        in_a[3] = 1'b0; push_a(62, 3, 1'b0);

        // ch3 starts counting, then reset lands at count 2
        wait_edge(69);
        in_a[3] = 1'b1;
        wait_edge(74);
        rst_n = 1'b0;
        wait_edge(75);
        chk("a_midreset_sigout", longint'(out_a), 0);
        chk("a_midreset_pulses", longint'({rise_a, fall_a}), 0);
        chk("b_midreset_sigout", longint'(out_b), 3);
        wait_edge(76);
        rst_n = 1'b1;
        push_a(83, 0, 1'b1);
        push_a(83, 3, 1'b1);
        push_b(81, 0, 1'b0);
        push_b(81, 1, 1'b0);

        // back-to-back accepted transitions on ch1, FILTER_CC apart
        wait_edge(89);
        in_a[1] = 1'b1; push_a(96, 1, 1'b1);
        wait_edge(93);
        in_a[1] = 1'b0; push_a(100, 1, 1'b0);
        wait_edge(97);
        in_a[1] = 1'b1; push_a(104, 1, 1'b1);
        wait_edge(101);
        in_a[1] = 1'b0; push_a(108, 1, 1'b0);

        wait_edge(119);
        in_a = 4'b0000;
        push_a(126, 0, 1'b0);
        push_a(126, 3, 1'b0);

        wait_edge(135);
        chk("a_queue_drained", longint'(q_a.size()), 0);
        chk("b_queue_drained", longint'(q_b.size()), 0);
        chk("a_final_sigout", longint'(out_a), 0);
        chk("b_final_sigout", longint'(out_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_filter_edge.md
SYNC_FILTER_EDGE -- requirements
Module: sync_filter_edge

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input bits (1..32).
REQ-002 SHALL have parameter SYNC_DELAY_CC, default 2, synchroniser stages after the capture flop (>=2).
REQ-003 SHALL have parameter FILTER_CC, default 4, consecutive cycles a new level must persist before acceptance (1..255).
REQ-004 SHALL have parameter INIT_LEVEL, default 0, per-channel reset level of all stages and outputs (0 or 1).
REQ-005 SHALL have port piul1SyncClock  input  1  sole clock; all flops on rising edge.
REQ-006 SHALL have port piul1SyncResetN  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port piulvSigIn  input  CHANNELS  asynchronous raw inputs.
REQ-008 SHALL have port poulvSigOut  output  CHANNELS  synchronised, glitch-filtered level L.
REQ-009 SHALL have port poulvRise  output  CHANNELS  one-cycle pulse on accepted 0->1 of L.
REQ-010 SHALL have port poulvFall  output  CHANNELS  one-cycle pulse on accepted 1->0 of L.

Function
REQ-011 Each channel SHALL be independent; no cross-channel logic.
REQ-012 Sync chain: SYNC_DELAY_CC+1 flops; value S = last stage; input sampled at edge k appears on S after edge k+SYNC_DELAY_CC.
REQ-013 Filter: per-channel counter, width clog2(FILTER_CC+1), range 0..FILTER_CC-1, never wraps.
REQ-014 Each edge: S==L -> counter<=0; S!=L and counter==FILTER_CC-1 -> L<=S, counter<=0; else counter<=counter+1.
REQ-015 Latency: input stable from edge k -> L changes at edge k+SYNC_DELAY_CC+FILTER_CC (defaults: 6 edges).
REQ-016 S pulse shorter than FILTER_CC cycles SHALL never change L nor produce a pulse; counter restarts from 0 on next differing run.
REQ-017 FILTER_CC=1 SHALL yield L = S delayed one register, no filtering.
REQ-018 poulvRise/poulvFall SHALL be registered, asserted on the same edge L changes, high exactly one cycle; never both high on a channel.
REQ-019 Back-to-back accepted transitions SHALL be at least FILTER_CC cycles apart; each yields its own pulse.
REQ-020 Outputs SHALL be pure flop outputs; no combinational path input->output.

Reset
REQ-021 While piul1SyncResetN=0 at an edge: all sync stages and L <= INIT_LEVEL, counters <= 0, pulses <= 0.
REQ-022 Reset mid-count SHALL discard pending count; no pulse in reset cycle.
REQ-023 After reset release, input differing from INIT_LEVEL SHALL be processed as a normal transition (pulse after REQ-015 latency).

Structure
REQ-024 Package sync_pkg SHALL hold default parameter constants and the counter-width function.
REQ-025 One sub-module sync_filter_chan (single-bit chain + filter + edge pulses) SHALL be instantiated CHANNELS times via generate.

Verification
REQ-026 Defaults, ch0 0->1 held before edge 10 -> SigOut[0]=1 and Rise[0]=1 after edge 16, Rise low after edge 17, other channels unchanged.
REQ-027 Defaults, ch1 high for 3 cycles then low -> SigOut[1] stays 0, no Rise/Fall ever.
REQ-028 Defaults, ch2 high 4 cycles from edge 20 -> Rise[2] after edge 26, Fall[2] exactly 4 edges after Rise.
REQ-029 Reset asserted at counter=2 on ch3, released -> no pulse; input still high -> Rise[3] 6 edges after release.
REQ-030 INIT_LEVEL=1, FILTER_CC=1, SYNC_DELAY_CC=3: input 0 at release -> Fall after edge 4, SigOut follows input with 4-edge latency.
REQ-031 CHANNELS=32, random async toggles with dwell >= 8 -> SigOut equals reference model, pulse count equals accepted transitions.
